// File: rtl/filter_bank_packetizer_if.sv
// Write port and NoC packet port of the filter bank packetizer.
// The slave modport is the packetizer's view; master is the driving/consuming side.
interface filter_bank_packetizer_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int PKT_W  = 57
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              load_done;
    logic              pkt_valid;
    logic              pkt_ready;
    logic [PKT_W-1:0]  pkt_data;

    modport slave (
        input  wr_valid, wr_addr, wr_data, load_done, pkt_ready,
        output wr_ready, pkt_valid, pkt_data
    );

    modport master (
        output wr_valid, wr_addr, wr_data, load_done, pkt_ready,
        input  wr_ready, pkt_valid, pkt_data
    );
endinterface

// File: rtl/filter_bank_packetizer.sv
// Ping-pong filter store: loads a DEPTH_F x DEPTH_F filter byte-wise and
// streams one NoC packet per filter row, loading the next filter meanwhile.
module filter_bank_packetizer #(
    parameter int DATA_W    = 8,
    parameter int DEPTH_F   = 5,
    parameter int NODE_ID   = 11,
    parameter int DEST_BASE = 1,
    parameter int MESH_X    = 5,
    parameter int ADDR_W    = 12,
    parameter int PKT_W     = 57
) (
    input  logic                    clk,
    input  logic                    rst_n,
    filter_bank_packetizer_if.slave bus,
    output logic                    busy_o,
    output logic [1:0]              err_o
);
    localparam int PAY_W  = DEPTH_F * DATA_W;
    localparam int ROW_W  = (DEPTH_F > 1) ? $clog2(DEPTH_F) : 1;
    localparam int NUM_EL = DEPTH_F * DEPTH_F;

    typedef enum logic {IDLE, SEND} state_e;

    state_e           state_q, state_d;
    logic [PAY_W-1:0] bank_q [2][DEPTH_F];
    logic [1:0]       full_q, full_d;
    logic             load_ptr_q, load_ptr_d;
    logic             send_ptr_q, send_ptr_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [PKT_W-1:0] pkt_q, pkt_d;
    logic [1:0]       err_q, err_d;
    logic             wr_accept;
    logic             addr_ok;
    logic             commit;

    // Hop fields use 0-based node numbers laid out row-major over the mesh.
    function automatic logic [PKT_W-1:0] buildPkt(input logic [PAY_W-1:0] payload,
                                                  input int rowIdx);
        int srcN, dstN, dx, dy;
        logic [PKT_W-1:0] pkt;
        srcN = NODE_ID - 1;
        dstN = DEST_BASE + rowIdx - 1;
        dx   = (dstN % MESH_X) - (srcN % MESH_X);
        dy   = (dstN / MESH_X) - (srcN / MESH_X);
        pkt  = '0;
        pkt[PAY_W-1:0] = payload;
        pkt[55:52]     = 4'(NODE_ID);
        pkt[51:48]     = 4'(DEST_BASE + rowIdx);
        pkt[47]        = (dx > 0);
        pkt[46:44]     = 3'((dx < 0) ? -dx : dx);
        pkt[43]        = (dy > 0);
        pkt[42:40]     = 3'((dy < 0) ? -dy : dy);
        return pkt;
    endfunction

    assign wr_accept     = bus.wr_valid & ~full_q[load_ptr_q];
    assign addr_ok       = (bus.wr_addr < ADDR_W'(NUM_EL));
    assign commit        = bus.load_done & ~full_q[load_ptr_q];
    assign bus.wr_ready  = ~full_q[load_ptr_q];
    assign bus.pkt_valid = (state_q == SEND);
    assign bus.pkt_data  = pkt_q;
    assign busy_o        = full_q[0] | full_q[1] | (state_q == SEND);
    assign err_o         = err_q;

    always_comb begin
        state_d    = state_q;
        full_d     = full_q;
        load_ptr_d = load_ptr_q;
        send_ptr_d = send_ptr_q;
        row_d      = row_q;
        pkt_d      = pkt_q;
        err_d      = err_q;

        if (wr_accept && !addr_ok)
            err_d[0] = 1'b1;
        if (bus.load_done && full_q[load_ptr_q])
            err_d[1] = 1'b1;
        if (commit) begin
            full_d[load_ptr_q] = 1'b1;
            load_ptr_d         = ~load_ptr_q;
        end

        unique case (state_q)
            IDLE: begin
                if (full_q[send_ptr_q]) begin
                    state_d = SEND;
                    row_d   = '0;
                    pkt_d   = buildPkt(bank_q[send_ptr_q][0], 0);
                end
            end
            SEND: begin
                if (bus.pkt_ready) begin
                    if (row_q == ROW_W'(DEPTH_F - 1)) begin
                        full_d[send_ptr_q] = 1'b0;
                        send_ptr_d         = ~send_ptr_q;
                        row_d              = '0;
                        // A committed second bank continues the stream without a bubble.
                        if (full_q[~send_ptr_q]) begin
                            pkt_d = buildPkt(bank_q[~send_ptr_q][0], 0);
                        end else begin
                            state_d = IDLE;
                            pkt_d   = '0;
                        end
                    end else begin
                        row_d = row_q + 1'b1;
                        pkt_d = buildPkt(bank_q[send_ptr_q][row_d], int'(row_d));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            full_q     <= '0;
            load_ptr_q <= 1'b0;
            send_ptr_q <= 1'b0;
            row_q      <= '0;
            pkt_q      <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            full_q     <= full_d;
            load_ptr_q <= load_ptr_d;
            send_ptr_q <= send_ptr_d;
            row_q      <= row_d;
            pkt_q      <= pkt_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < DEPTH_F; r++)
                    bank_q[b][r] <= '0;
        end else if (wr_accept && addr_ok) begin
            for (int r = 0; r < DEPTH_F; r++)
                for (int c = 0; c < DEPTH_F; c++)
                    if (bus.wr_addr == ADDR_W'(r * DEPTH_F + c))
                        bank_q[load_ptr_q][r][c*DATA_W +: DATA_W] <= bus.wr_data;
        end
    end
endmodule

// File: tb/tb_filter_bank_packetizer.sv
// Directed bench for filter_bank_packetizer with default parameters;
// expected packets come from hand-computed header words plus the written bytes.
module tb_filter_bank_packetizer;
    logic       clk;
    logic       rst_n;
    logic       busy;
    logic [1:0] err;
    int         assertCount;
    int         failCount;

    filter_bank_packetizer_if #(.ADDR_W(12), .DATA_W(8), .PKT_W(57)) bus ();

    filter_bank_packetizer #(
        .DATA_W(8), .DEPTH_F(5), .NODE_ID(11), .DEST_BASE(1),
        .MESH_X(5), .ADDR_W(12), .PKT_W(57)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus.slave),
        .busy_o (busy),
        .err_o  (err)
    );

    // Free-running 10 ns clock; inputs change and outputs are sampled on the falling edge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit so a stuck design still ends the run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [11:0] addr, input logic [7:0] data,
                                 input logic withLoadDone);
        bus.wr_valid  = 1'b1;
        bus.wr_addr   = addr;
        bus.wr_data   = data;
        bus.load_done = withLoadDone;
        tick();
        bus.wr_valid  = 1'b0;
        bus.load_done = 1'b0;
    endtask

    task automatic loadFilter(input logic [7:0] base);
        for (int k = 0; k < 25; k++)
            applyStimulus(12'(k), base + 8'(k), 1'b0);
    endtask

    task automatic pulseLoadDone();
        bus.load_done = 1'b1;
        tick();
        bus.load_done = 1'b0;
    endtask

    // Headers for rows 0..4: src 11 at (0,2); dest 1..5 at (0..4,0).
    function automatic logic [63:0] expPkt(input logic [7:0] base, input int r,
                                           input logic [7:0] ovr24, input bit useOvr);
        logic [15:0] hdr;
        logic [39:0] pay;
        logic [7:0]  b;
        case (r)
            0:       hdr = 16'hB102;
            1:       hdr = 16'hB292;
            2:       hdr = 16'hB3A2;
            3:       hdr = 16'hB4B2;
            default: hdr = 16'hB5C2;
        endcase
        for (int c = 0; c < 5; c++) begin
            b = base + 8'(r * 5 + c);
            if (useOvr && (r * 5 + c == 24))
                b = ovr24;
            pay[c*8 +: 8] = b;
        end
        return {8'h00, hdr, pay};
    endfunction

    // Expects pkt_ready already high and row 0 presented now.
    task automatic collectRows(input string tag, input logic [7:0] base,
                               input logic [7:0] ovr24, input bit useOvr);
        for (int r = 0; r < 5; r++) begin
            checkOutput({tag, "_valid"}, 64'(bus.pkt_valid), 64'd1);
            checkOutput({tag, "_data"}, 64'(bus.pkt_data), expPkt(base, r, ovr24, useOvr));
            tick();
        end
    endtask

    initial begin
        int acc;
        assertCount   = 0;
        failCount     = 0;
        rst_n         = 1'b0;
        bus.wr_valid  = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.load_done = 1'b0;
        bus.pkt_ready = 1'b0;

        @(negedge clk);
        checkOutput("rst_wr_ready", 64'(bus.wr_ready), 64'd1);
        checkOutput("rst_pkt_valid", 64'(bus.pkt_valid), 64'd0);
        checkOutput("rst_pkt_data", 64'(bus.pkt_data), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Load k -> k, commit, first packet one cycle after the commit edge.
        loadFilter(8'h00);
        pulseLoadDone();
        checkOutput("t1_valid_early", 64'(bus.pkt_valid), 64'd0);
        checkOutput("t1_busy", 64'(busy), 64'd1);
        tick();
        checkOutput("t1_valid", 64'(bus.pkt_valid), 64'd1);
        checkOutput("t1_pkt0_lit", 64'(bus.pkt_data), 64'h0B1020403020100);
        tick();
        checkOutput("t1_hold", 64'(bus.pkt_data), 64'h0B1020403020100);

        // Continuous ready streams all five rows back-to-back.
        bus.pkt_ready = 1'b1;
        for (int r = 0; r < 5; r++) begin
            checkOutput("t2_valid", 64'(bus.pkt_valid), 64'd1);
            checkOutput("t2_data", 64'(bus.pkt_data), expPkt(8'h00, r, 8'h00, 1'b0));
            checkOutput("t2_busy", 64'(busy), 64'd1);
            if (r == 2)
                checkOutput("t2_pkt2_lit", 64'(bus.pkt_data), 64'h0B3A20E0D0C0B0A);
            tick();
        end
        bus.pkt_ready = 1'b0;
        checkOutput("t2_valid_off", 64'(bus.pkt_valid), 64'd0);
        checkOutput("t2_busy_off", 64'(busy), 64'd0);

        // Alternating ready: data must stay on the unaccepted row while stalled.
        loadFilter(8'h00);
        pulseLoadDone();
        acc = 0;
        for (int cyc = 0; cyc < 40 && acc < 5; cyc++) begin
            bus.pkt_ready = (cyc % 2 == 0);
            if (bus.pkt_valid) begin
                checkOutput("t3_data", 64'(bus.pkt_data), expPkt(8'h00, acc, 8'h00, 1'b0));
                if (bus.pkt_ready)
                    acc++;
            end
            tick();
        end
        bus.pkt_ready = 1'b0;
        checkOutput("t3_accepts", 64'(acc), 64'd5);
        checkOutput("t3_valid_off", 64'(bus.pkt_valid), 64'd0);

        // Two banks committed, then an extra commit with no free bank.
        loadFilter(8'h00);
        pulseLoadDone();
        loadFilter(8'h40);
        pulseLoadDone();
        checkOutput("t4_wr_ready", 64'(bus.wr_ready), 64'd0);
        pulseLoadDone();
        checkOutput("t4_err", 64'(err), 64'd2);
        checkOutput("t4_wr_ready2", 64'(bus.wr_ready), 64'd0);
        bus.pkt_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checkOutput("t4_valid", 64'(bus.pkt_valid), 64'd1);
            checkOutput("t4_data", 64'(bus.pkt_data),
                        expPkt((i < 5) ? 8'h00 : 8'h40, i % 5, 8'h00, 1'b0));
            tick();
        end
        bus.pkt_ready = 1'b0;
        checkOutput("t4_valid_off", 64'(bus.pkt_valid), 64'd0);
        checkOutput("t4_busy_off", 64'(busy), 64'd0);

        // Out-of-range write is dropped; a write coincident with commit lands in it.
        applyStimulus(12'd25, 8'h99, 1'b0);
        checkOutput("t5_err_addr", 64'(err), 64'd3);
        applyStimulus(12'd24, 8'hEE, 1'b1);
        tick();
        bus.pkt_ready = 1'b1;
        collectRows("t5", 8'h00, 8'hEE, 1'b1);
        bus.pkt_ready = 1'b0;
        checkOutput("t5_valid_off", 64'(bus.pkt_valid), 64'd0);

        // Reset in the middle of a send, then a fresh load restarts at row 0.
        loadFilter(8'h80);
        pulseLoadDone();
        tick();
        bus.pkt_ready = 1'b1;
        tick();
        tick();
        checkOutput("t6_mid_row2", 64'(bus.pkt_data), expPkt(8'h80, 2, 8'h00, 1'b0));
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_valid", 64'(bus.pkt_valid), 64'd0);
        checkOutput("t6_rst_busy", 64'(busy), 64'd0);
        checkOutput("t6_rst_err", 64'(err), 64'd0);
        checkOutput("t6_rst_data", 64'(bus.pkt_data), 64'd0);
        bus.pkt_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        loadFilter(8'h20);
        pulseLoadDone();
        tick();
        bus.pkt_ready = 1'b1;
        collectRows("t6", 8'h20, 8'h00, 1'b0);
        bus.pkt_ready = 1'b0;
        checkOutput("t6_valid_off", 64'(bus.pkt_valid), 64'd0);
        checkOutput("t6_err_clean", 64'(err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
